// File: rtl/gray_counter_codec.sv
// Up/down binary counter with a registered Gray twin, plus an independent
// one-cycle Gray-to-binary decode channel.
module gray_counter_codec #(
    parameter int WIDTH  = 4,
    parameter int DEC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             wrap,
    input  logic             dec_vld_in,
    input  logic [WIDTH-1:0] dec_gray_in,
    output logic             dec_vld_out,
    output logic [WIDTH-1:0] dec_bin_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // Load beats counting; wrap only flags a counted step across the boundary.
    always_comb begin
        bin_nxt  = cnt_bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
            if (up_dn) begin
                bin_nxt  = cnt_bin + ONE;
                wrap_nxt = (cnt_bin == ALL_ONES);
            end else begin
                bin_nxt  = cnt_bin - ONE;
                wrap_nxt = (cnt_bin == '0);
            end
        end
    end

    // Gray is derived from the next binary value so both registers update together.
    assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_bin  <= '0;
            cnt_gray <= '0;
            wrap     <= 1'b0;
        end else begin
            cnt_bin  <= bin_nxt;
            cnt_gray <= gray_nxt;
            wrap     <= wrap_nxt;
        end
    end

    generate
        if (DEC_EN != 0) begin : g_dec
            function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
                logic [WIDTH-1:0] b;
                b            = '0;
                b[WIDTH-1]   = g[WIDTH-1];
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    b[i] = b[i+1] ^ g[i];
                end
                return b;
            endfunction

            always_ff @(posedge clk) begin
                if (rst) begin
                    dec_vld_out <= 1'b0;
                    dec_bin_out <= '0;
                end else begin
                    dec_vld_out <= dec_vld_in;
                    if (dec_vld_in) begin
                        dec_bin_out <= gray_to_bin(dec_gray_in);
                    end
                end
            end
        end else begin : g_no_dec
            logic unused_dec;
            assign unused_dec  = ^{dec_vld_in, dec_gray_in};
            assign dec_vld_out = 1'b0;
            assign dec_bin_out = '0;
        end
    endgenerate

endmodule

// File: tb/tb_gray_counter_codec.sv
// Bench for gray_counter_codec: directed literal checks, a randomized run against
// a table-driven model, a 6-bit exhaustive round trip and a decode-less instance.
module tb_gray_counter_codec;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, load, dec_vld_in;
    logic [3:0] load_bin, dec_gray_in;
    logic [3:0] cnt_bin, cnt_gray, dec_bin_out;
    logic       wrap, dec_vld_out;

    logic [3:0] n_cnt_bin, n_cnt_gray, n_dec_bin_out;
    logic       n_wrap, n_dec_vld_out;

    logic       ld6;
    logic [5:0] lb6, cnt_bin6, cnt_gray6, dec_bin6;
    logic       wrap6, dec_vld6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_counter_codec #(.WIDTH(4), .DEC_EN(1)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .cnt_bin(cnt_bin), .cnt_gray(cnt_gray), .wrap(wrap),
        .dec_vld_in(dec_vld_in), .dec_gray_in(dec_gray_in),
        .dec_vld_out(dec_vld_out), .dec_bin_out(dec_bin_out)
    );

    gray_counter_codec #(.WIDTH(4), .DEC_EN(0)) dut_nodec (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .cnt_bin(n_cnt_bin), .cnt_gray(n_cnt_gray), .wrap(n_wrap),
        .dec_vld_in(dec_vld_in), .dec_gray_in(dec_gray_in),
        .dec_vld_out(n_dec_vld_out), .dec_bin_out(n_dec_bin_out)
    );

    // The 6-bit instance decodes its own counter's Gray output.
    gray_counter_codec #(.WIDTH(6), .DEC_EN(1)) dut6 (
        .clk(clk), .rst(rst), .en(1'b0), .up_dn(1'b0), .load(ld6), .load_bin(lb6),
        .cnt_bin(cnt_bin6), .cnt_gray(cnt_gray6), .wrap(wrap6),
        .dec_vld_in(1'b1), .dec_gray_in(cnt_gray6),
        .dec_vld_out(dec_vld6), .dec_bin_out(dec_bin6)
    );

    // Reflected Gray table built by mirroring; decode is its inverse lookup.
    int gtab[64];
    initial begin
        gtab[0] = 0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gtab[(1 << k) + i] = (1 << k) | gtab[(1 << k) - 1 - i];
            end
        end
    end

    function automatic int inv_gray(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            if (gtab[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the 4-bit instances.
    int m_bin = 0, m_wrap = 0, m_dv = 0, m_db = 0, m_prev_gray = 0, m_step = 0;
    bit started = 1'b0;

    always @(posedge clk) begin
        m_prev_gray = gtab[m_bin];
        m_step      = 0;
        if (rst) begin
            m_bin = 0; m_wrap = 0; m_dv = 0; m_db = 0;
        end else begin
            m_wrap = 0;
            if (load) begin
                m_bin = int'(load_bin);
            end else if (en) begin
                m_step = 1;
                if (up_dn) begin
                    m_wrap = (m_bin == 15) ? 1 : 0;
                    m_bin  = (m_bin + 1) % 16;
                end else begin
                    m_wrap = (m_bin == 0) ? 1 : 0;
                    m_bin  = (m_bin + 15) % 16;
                end
            end
            m_dv = dec_vld_in ? 1 : 0;
            if (dec_vld_in) m_db = inv_gray(int'(dec_gray_in), 16);
        end
        started = 1'b1;
        #1;
        chk("cnt_bin", 32'(cnt_bin), 32'(m_bin));
        chk("cnt_gray", 32'(cnt_gray), 32'(gtab[m_bin]));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("dec_vld_out", 32'(dec_vld_out), 32'(m_dv));
        chk("dec_bin_out", 32'(dec_bin_out), 32'(m_db));
        chk("nodec_cnt_bin", 32'(n_cnt_bin), 32'(m_bin));
        chk("nodec_cnt_gray", 32'(n_cnt_gray), 32'(gtab[m_bin]));
        chk("nodec_wrap", 32'(n_wrap), 32'(m_wrap));
        chk("nodec_dec_vld", 32'(n_dec_vld_out), 32'd0);
        chk("nodec_dec_bin", 32'(n_dec_bin_out), 32'd0);
        if (m_step == 1) chk("gray_hamming", 32'($countones(cnt_gray ^ 4'(m_prev_gray))), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int seq[18] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1};
    int dg[5]   = '{0, 8, 15, 0, 11};
    int dv[5]   = '{1, 1, 1, 0, 1};
    int db[5]   = '{0, 15, 10, 10, 13};

    initial begin
        rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_bin = '0;
        dec_vld_in = 1'b1; dec_gray_in = 4'h5; ld6 = 1'b0; lb6 = '0;

        // Reset held two cycles with enable and decode requests active.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_cnt_bin", 32'(cnt_bin), 32'd0);
            chk("rst_cnt_gray", 32'(cnt_gray), 32'd0);
            chk("rst_wrap", 32'(wrap), 32'd0);
            chk("rst_dec_vld", 32'(dec_vld_out), 32'd0);
            chk("rst_dec_bin", 32'(dec_bin_out), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; dec_vld_in = 1'b0;
        chk("post_rst_cnt_bin", 32'(cnt_bin), 32'd0);

        // Up count through the wrap.
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("up_gray_seq", 32'(cnt_gray), 32'(seq[k]));
            chk("up_wrap", 32'(wrap), (k == 16) ? 32'd1 : 32'd0);
        end

        // Down count from zero.
        @(negedge clk); load = 1'b1; load_bin = 4'h0; en = 1'b0;
        tick();
        chk("load0_bin", 32'(cnt_bin), 32'd0);
        chk("load0_wrap", 32'(wrap), 32'd0);
        @(negedge clk); load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        chk("down_bin", 32'(cnt_bin), 32'hF);
        chk("down_gray", 32'(cnt_gray), 32'h8);
        chk("down_wrap", 32'(wrap), 32'd1);
        tick();
        chk("down2_bin", 32'(cnt_bin), 32'hE);
        chk("down2_gray", 32'(cnt_gray), 32'h9);
        chk("down2_wrap", 32'(wrap), 32'd0);

        // Load wins over count; the following count wraps.
        @(negedge clk); load = 1'b1; load_bin = 4'hF; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("loadF_bin", 32'(cnt_bin), 32'hF);
        chk("loadF_gray", 32'(cnt_gray), 32'h8);
        chk("loadF_wrap", 32'(wrap), 32'd0);
        @(negedge clk); load = 1'b0;
        tick();
        chk("after_load_bin", 32'(cnt_bin), 32'h0);
        chk("after_load_wrap", 32'(wrap), 32'd1);

        // Decode stream with a gap while the counter keeps running.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dec_vld_in  = dv[k][0];
            dec_gray_in = (dv[k] == 1) ? 4'(dg[k]) : 4'($urandom_range(0, 15));
            tick();
            chk("dec_stream_vld", 32'(dec_vld_out), 32'(dv[k]));
            chk("dec_stream_bin", 32'(dec_bin_out), 32'(db[k]));
        end

        // Randomized run, with occasional resets and boundary-biased loads.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 49) == 0);
            load        = ($urandom_range(0, 7) == 0);
            en          = ($urandom_range(0, 3) != 0);
            up_dn       = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       load_bin = 4'h0;
                1:       load_bin = 4'hF;
                default: load_bin = 4'($urandom_range(0, 15));
            endcase
            dec_vld_in  = ($urandom_range(0, 1) == 1);
            dec_gray_in = 4'($urandom_range(0, 15));
        end
        @(negedge clk); rst = 1'b0; load = 1'b0; en = 1'b0; dec_vld_in = 1'b0;

        // Exhaustive 6-bit load / decode round trip.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); ld6 = 1'b1; lb6 = 6'(i);
            tick();
            chk("w6_gray", 32'(cnt_gray6), 32'(gtab[i]));
            chk("w6_wrap", 32'(wrap6), 32'd0);
            @(negedge clk); ld6 = 1'b0;
            tick();
            chk("w6_dec_vld", 32'(dec_vld6), 32'd1);
            chk("w6_roundtrip", 32'(dec_bin6), 32'(i));
        end

        // Second reset with requests active; decode-less instance covered by the model process.
        @(negedge clk); rst = 1'b1; en = 1'b1; dec_vld_in = 1'b1; dec_gray_in = 4'hA;
        tick(); tick();
        chk("rst2_nodec_vld", 32'(n_dec_vld_out), 32'd0);
        chk("rst2_nodec_bin", 32'(n_dec_bin_out), 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("post_rst2_nodec_vld", 32'(n_dec_vld_out), 32'd0);
        chk("post_rst2_nodec_bin", 32'(n_dec_bin_out), 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
